// File: rtl/div_pkg.sv
// Shared definitions for the multi-cycle divide controller and its datapath step.
package div_pkg;

  localparam int DIV_WIDTH = 32;
  localparam int DIV_ITERS = DIV_WIDTH;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_SIGN = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/div_iter.sv
// One combinational radix-2 restoring step on {rem, quo} against the divisor magnitude.
module div_iter
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] babs_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0] shifted_rem;
  logic [WIDTH:0] trial;

  // The bit shifted out of rem is kept as bit WIDTH so unsigned divisors near 2^WIDTH still work.
  assign shifted_rem = {rem_i, quo_i[WIDTH-1]};
  assign trial       = shifted_rem - {1'b0, babs_i};

  always_comb begin
    rem_o = shifted_rem[WIDTH-1:0];
    quo_o = {quo_i[WIDTH-2:0], 1'b0};
    if (!trial[WIDTH]) begin
      rem_o    = trial[WIDTH-1:0];
      quo_o[0] = 1'b1;
    end
  end

endmodule

// File: rtl/div_sequencer.sv
// DIV/DIVU controller: latches operand magnitudes, iterates restoring division,
// applies sign fix-up and publishes HI (remainder) / LO (quotient), stalling the pipe meanwhile.
module div_sequencer
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_ITERS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             cancel_i,
  output logic             stall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = $clog2(WIDTH) + 1;

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] babs_q, babs_d;
  logic             qsign_q, qsign_d;
  logic             rsign_q, rsign_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             a_neg, b_neg;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [WIDTH-1:0] iter_rem, iter_quo;

  assign a_neg = signed_i & a_i[WIDTH-1];
  assign b_neg = signed_i & b_i[WIDTH-1];
  assign a_abs = a_neg ? -a_i : a_i;
  assign b_abs = b_neg ? -b_i : b_i;

  div_iter #(.WIDTH(WIDTH)) u_iter (
    .rem_i  (rem_q),
    .quo_i  (quo_q),
    .babs_i (babs_q),
    .rem_o  (iter_rem),
    .quo_o  (iter_quo)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    babs_d  = babs_q;
    qsign_d = qsign_q;
    rsign_d = rsign_q;
    hi_d    = hi_q;
    lo_d    = lo_q;

    case (state_q)
      ST_IDLE: begin
        if (start_i && !cancel_i) begin
          babs_d  = b_abs;
          qsign_d = a_neg ^ b_neg;
          rsign_d = a_neg;
          rem_d   = '0;
          quo_d   = a_abs;
          cnt_d   = '0;
          if (b_i == '0) begin
            hi_d    = a_i;
            lo_d    = '1;
            state_d = ST_DONE;
          end else begin
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        rem_d = iter_rem;
        quo_d = iter_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = ST_SIGN;
        end
      end
      ST_SIGN: begin
        lo_d    = qsign_q ? -quo_q : quo_q;
        hi_d    = rsign_q ? -rem_q : rem_q;
        cnt_d   = '0;
        state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
    endcase

    // A flush abandons the operation without touching the published results.
    if (cancel_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end

    busy_d = (state_d != ST_IDLE);
    done_d = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      babs_q  <= '0;
      qsign_q <= 1'b0;
      rsign_q <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      babs_q  <= babs_d;
      qsign_q <= qsign_d;
      rsign_q <= rsign_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign stall_o = ~cancel_i & ~rst &
                   (((state_q == ST_IDLE) & start_i) | (state_q == ST_CALC) | (state_q == ST_SIGN));
  assign busy_o  = busy_q;
  assign done_o  = done_q;
  assign hi_o    = hi_q;
  assign lo_o    = lo_q;

endmodule

// File: doc/div_sequencer.md
# div_sequencer

Multi-cycle controller for the DIV/DIVU datapath in the EX stage. It accepts a divide request from the decoded instruction, runs a 32-iteration radix-2 restoring division, applies the sign fix-up, and writes quotient/remainder to the HI/LO result registers. While it runs, it drives the pipeline stall. An exception flush cancels it at any point.

## Interface

Parameters:
- `WIDTH`, default 32: operand and result width. Iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `start_i`  in  1  EX holds a DIV/DIVU; level signal, sampled only in IDLE.
- `signed_i`  in  1  1 = DIV (two's complement), 0 = DIVU.
- `a_i`  in  WIDTH  dividend (rs).
- `b_i`  in  WIDTH  divisor (rt).
- `cancel_i`  in  1  exception flush (`flush_exceptM`); aborts the operation.
- `stall_o`  out  1  hold IF/ID/EX; combinational.
- `busy_o`  out  1  state is not IDLE; registered.
- `done_o`  out  1  one-cycle pulse; `hi_o`/`lo_o` are valid.
- `hi_o`  out  WIDTH  remainder; registered, held until the next completion.
- `lo_o`  out  WIDTH  quotient; registered, held until the next completion.

## Operation

- States are IDLE, CALC, SIGN and DONE.
- **IDLE**
  - When `start_i` is high and `cancel_i` is low, latch |a|, |b|, the quotient sign (sa^sb) and the remainder sign (sa). The signs are zero when `signed_i` is 0.
  - If `b_i` is 0, go to DONE with `hi_o`=`a_i` and `lo_o`=all-ones. Otherwise go to CALC with the iteration counter at 0.
- **CALC**, one step per cycle on a 2·WIDTH register {rem, quo}:
  - Shift the register left by 1.
  - Compute trial = rem − |b| at WIDTH+1 bits.
  - If the trial is non-negative, rem ← trial and quo[0] ← 1.
  - After WIDTH steps, go to SIGN.
- **SIGN**
  - Negate quo if the quotient sign is set; negate rem if the remainder sign is set. Negation is two's complement, mod 2^WIDTH.
  - Register the results into `lo_o`/`hi_o`, then go to DONE.
- **DONE**
  - `done_o` is 1 and `start_i` is ignored; next state is IDLE.
- **Overflow case:** 0x80000000 / −1 gives `lo_o`=0x80000000 and `hi_o`=0. This falls out of the mod-2^32 arithmetic and needs no special case.
- **Cancel:** `cancel_i` in any state sends the next state to IDLE.
  - No `done_o`, and `hi_o`/`lo_o` are not updated.
  - In IDLE, `cancel_i` wins over `start_i`.
- **Stall:** `stall_o` = ~`cancel_i` & ~`rst` & ((IDLE & `start_i`) | CALC | SIGN).
- **Reset:** all outputs and state reach these values asynchronously, including in the middle of an operation.
  - State = IDLE, counter = 0.
  - `hi_o` = `lo_o` = 0, `done_o` = 0, `busy_o` = 0, `stall_o` = 0.

## Timing

- **Normal divide**, accepted in cycle T:
  - CALC runs T+1..T+WIDTH and SIGN is T+WIDTH+1.
  - DONE is T+WIDTH+2: `done_o`=1, results visible, `stall_o`=0.
  - For WIDTH=32, `stall_o` is high for 34 cycles (T..T+33).
- **Divide by zero:** `stall_o` is high in T only; DONE/`done_o` in T+1.
- Results change only on the edge that enters DONE.
- **Back-to-back divides:** after DONE the pipeline advances and the next DIV is accepted from IDLE no earlier than T+WIDTH+3.
- `busy_o` is high from T+1 through DONE inclusive.

## Structure

- Shared package `div_pkg`: state enum (IDLE, CALC, SIGN, DONE) and localparam `DIV_ITERS` = WIDTH.
- Counter width: $clog2(WIDTH)+1.
- Sub-module `div_iter`: combinational single restoring step, {rem, quo}, |b| → {rem', quo'}. It is instantiated once and used every CALC cycle.

## Test plan

- DIVU a=100, b=7, start at T → `stall_o` high T..T+33; `done_o` at T+34 with `lo_o`=14, `hi_o`=2; `busy_o` low at T+35.
- DIV a=0xFFFFFFF9 (−7), b=2 → `lo_o`=0xFFFFFFFD (−3), `hi_o`=0xFFFFFFFF (−1). Then DIVU with the same operands → `lo_o`=0x7FFFFFFC, `hi_o`=1.
- DIV a=0x80000000, b=0xFFFFFFFF → `lo_o`=0x80000000, `hi_o`=0. DIV a=5, b=0 → `done_o` at T+1 with `hi_o`=5, `lo_o`=0xFFFFFFFF.
- Start at T, `cancel_i` pulse at T+10 → `stall_o`=0 at T+10; IDLE at T+11; no `done_o` ever; `hi_o`/`lo_o` unchanged. New DIVU 9/3 at T+12 → `lo_o`=3, `hi_o`=0 at T+46.
- `start_i` and `cancel_i` both high in IDLE → not accepted and `stall_o`=0. Assert `rst` asynchronously mid-CALC → all outputs 0 immediately and state IDLE.
